// File: rtl/fp_divider.sv
// fp_divider: iterative IEEE-754 single-precision divider, divOut = op1 / op2.
// A radix-2 restoring mantissa divider produces one quotient bit per cycle.
// Rounding is truncation. Overflow gives a signed infinity and underflow a
// signed zero. Denormal inputs count as zero, and no denormals are produced.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request; sampled only while idle
//   op1    - dividend (binary32), captured on the accepting edge
//   op2    - divisor  (binary32), captured on the accepting edge
//   busy   - high from the cycle after acceptance until the done cycle
//   done   - one-cycle pulse; divOut is valid in that cycle
//   divOut - registered result, held until the next done
//
// Flow: IDLE -> CLASS (decode the latched operands) -> SPEC or DIV -> NORM -> IDLE.
// The CLASS cycle is why a special result appears 2 edges after acceptance
// and a computed result appears 27 edges after acceptance.

module fp_divider #(
    parameter int QBITS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        done,
    output logic [31:0] divOut
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLASS = 3'd1,
        SPEC  = 3'd2,
        DIV   = 3'd3,
        NORM  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Operand classification helpers
    // ------------------------------------------------------------------
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    endfunction

    // A zero exponent covers both true zeros and denormals.
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00);
    endfunction

    function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
        return is_nan(a) || is_nan(b) || is_inf(a) || is_inf(b) ||
               is_zero(a) || is_zero(b);
    endfunction

    // Special results, checked in priority order.
    function automatic logic [31:0] special_result(input logic [31:0] a,
                                                   input logic [31:0] b,
                                                   input logic        s);
        logic [31:0] r;
        if (is_nan(a) || is_nan(b)) begin
            r = 32'h7FC0_0000;
        end else if ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b))) begin
            r = 32'h7FC0_0000;
        end else if (is_inf(a)) begin
            r = {s, 8'hFF, 23'h0};
        end else if (is_zero(b)) begin
            r = {s, 8'hFF, 23'h0};
        end else begin
            // The two remaining cases are 0/x and x/inf. Both give a signed zero.
            r = {s, 31'h0};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_r, state_n;
    logic [31:0] a_r, a_n;
    logic [31:0] b_r, b_n;
    logic        sign_r, sign_n;
    logic [24:0] rem_r, rem_n;      // remainder is always < 2 * divisor
    logic [23:0] dvs_r, dvs_n;      // divisor significand with hidden bit
    logic [QBITS-1:0] q_r, q_n;
    logic [4:0]  cnt_r, cnt_n;
    logic        busy_r, busy_n;
    logic        done_r, done_n;
    logic [31:0] out_r, out_n;

    // Datapath helper signals
    logic [24:0]       rem_sub;
    logic              q_bit;
    logic signed [9:0] exp_raw;
    logic signed [9:0] exp_adj;
    logic [22:0]       mant;
    logic [31:0]       norm_result;

    assign busy   = busy_r;
    assign done   = done_r;
    assign divOut = out_r;

    // Register update with asynchronous reset of all state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= 32'h0;
            b_r     <= 32'h0;
            sign_r  <= 1'b0;
            rem_r   <= 25'h0;
            dvs_r   <= 24'h0;
            q_r     <= '0;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            out_r   <= 32'h0;
        end else begin
            state_r <= state_n;
            a_r     <= a_n;
            b_r     <= b_n;
            sign_r  <= sign_n;
            rem_r   <= rem_n;
            dvs_r   <= dvs_n;
            q_r     <= q_n;
            cnt_r   <= cnt_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            out_r   <= out_n;
        end
    end

    // Restoring step: compare, conditionally subtract, and emit the quotient bit.
    always_comb begin
        rem_sub = rem_r;
        q_bit   = 1'b0;
        if (rem_r >= {1'b0, dvs_r}) begin
            rem_sub = rem_r - {1'b0, dvs_r};
            q_bit   = 1'b1;
        end else begin
            rem_sub = rem_r;
            q_bit   = 1'b0;
        end
    end

    // Normalisation and exponent range check on the finished quotient.
    always_comb begin
        exp_raw = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'sd127;
        exp_adj = exp_raw;
        mant    = 23'h0;
        if (q_r[24]) begin
            mant    = q_r[23:1];
            exp_adj = exp_raw;
        end else begin
            // The mantissa ratio is below 1, so shift one place and lower the exponent.
            mant    = q_r[22:0];
            exp_adj = exp_raw - 10'sd1;
        end
        if (exp_adj > 10'sd254) begin
            norm_result = {sign_r, 8'hFF, 23'h0};
        end else if (exp_adj < 10'sd1) begin
            norm_result = {sign_r, 31'h0};
        end else begin
            norm_result = {sign_r, exp_adj[7:0], mant};
        end
    end

    // Next-state and register-input logic for the FSM.
    always_comb begin
        state_n = state_r;
        a_n     = a_r;
        b_n     = b_r;
        sign_n  = sign_r;
        rem_n   = rem_r;
        dvs_n   = dvs_r;
        q_n     = q_r;
        cnt_n   = cnt_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        out_n   = out_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    a_n     = op1;
                    b_n     = op2;
                    sign_n  = op1[31] ^ op2[31];
                    busy_n  = 1'b1;
                    state_n = CLASS;
                end else begin
                    state_n = IDLE;
                end
            end
            CLASS: begin
                if (is_special(a_r, b_r)) begin
                    state_n = SPEC;
                end else begin
                    rem_n   = {2'b01, a_r[22:0]};
                    dvs_n   = {1'b1, b_r[22:0]};
                    q_n     = '0;
                    cnt_n   = 5'd24;
                    state_n = DIV;
                end
            end
            SPEC: begin
                out_n   = special_result(a_r, b_r, sign_r);
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            DIV: begin
                // rem_sub < divisor < 2^24, so dropping bit 24 on the shift is safe.
                rem_n = {rem_sub[23:0], 1'b0};
                q_n   = {q_r[QBITS-2:0], q_bit};
                if (cnt_r == 5'd0) begin
                    state_n = NORM;
                end else begin
                    cnt_n = cnt_r - 5'd1;
                end
            end
            NORM: begin
                out_n   = norm_result;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_divider.sv
// Directed testbench for fp_divider. The expected values are worked out by hand
// in IEEE-754 binary32 with truncation. Latency is counted in clock edges from
// the edge that accepts start.

module tb_fp_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] divOut;

    int total;
    int bad;
    int cyc;

    fp_divider dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .divOut (divOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one start. Return right after the accepting edge, with c0 set to that edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, output int c0);
        @(negedge clk);
        op1   = a;
        op2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    // Wait (bounded) for done. Return the edge count since c0 and the busy-cycle count.
    task automatic wait_done(input int c0, output int lat, output int busy_cnt);
        busy_cnt = 0;
        while (!done && (cyc - c0) < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
        lat = cyc - c0;
    endtask

    // Full operation: latency, busy duration, result, busy low in the done cycle, and a one-cycle pulse.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input string tag);
        int c0;
        int lat;
        int bc;
        launch(a, b, c0);
        wait_done(c0, lat, bc);
        chk(lat, exp_lat, {tag, "_latency"});
        chk(divOut, exp_res, {tag, "_result"});
        chk(bc, exp_lat, {tag, "_busy_cycles"});
        chk({31'h0, busy}, 32'h0, {tag, "_busy_in_done"});
        @(posedge clk);
        #1;
        chk({31'h0, done}, 32'h0, {tag, "_done_pulse"});
        chk(divOut, exp_res, {tag, "_held"});
    endtask

    initial begin
        int c0;
        int lat;
        int bc;
        int pulses;

        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        start = 1'b0;
        op1   = 32'h0;
        op2   = 32'h0;
        #1;
        chk({31'h0, busy}, 32'h0, "reset_busy");
        chk({31'h0, done}, 32'h0, "reset_done");
        chk(divOut, 32'h0, "reset_divout");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Normal path
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, "div_6_2");
        do_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 27, "div_m6_2");
        do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27, "div_1_3");

        // Special operands
        do_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 2, "x_div_0");
        do_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 2, "zero_div_zero");
        do_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 2, "nan_div_1");
        do_op(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 2, "one_div_minf");

        // Range limits
        do_op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 27, "overflow");
        do_op(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 27, "underflow");

        // A start during an operation is ignored.
        launch(32'h40C0_0000, 32'h4000_0000, c0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op1   = 32'h3F80_0000;
        op2   = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c0, lat, bc);
        chk(lat, 27, "ignored_start_latency");
        chk(divOut, 32'h4040_0000, "ignored_start_result");

        // Back-to-back start in the done cycle.
        @(negedge clk);
        op1   = 32'hC0C0_0000;
        op2   = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
        chk({31'h0, busy}, 32'h1, "b2b_accepted_busy");
        wait_done(c0, lat, bc);
        chk(lat, 27, "b2b_latency");
        chk(divOut, 32'hC040_0000, "b2b_result");
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk(pulses, 0, "no_extra_done");

        // Asynchronous reset in the middle of a divide.
        launch(32'h3F80_0000, 32'h4040_0000, c0);
        while ((cyc - c0) < 10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk({31'h0, busy}, 32'h0, "abort_busy");
        chk({31'h0, done}, 32'h0, "abort_done");
        chk(divOut, 32'h0, "abort_divout");
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk(pulses, 0, "abort_no_done");
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
